gs_controller: RTL

GS_CONTROLLER -- requirements
Module: gs_controller

---
 rtl/gs_pkg.sv | 30 +++
 rtl/gs_xbuf.sv | 60 ++++++
 rtl/gs_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gs_pkg.sv
// Shared constants, counter widths and state encoding for the Gauss-Seidel sweep controller.
package gs_pkg;

  localparam int GS_N       = 16;
  localparam int GS_ITER    = 8;
  localparam int GS_TIMEOUT = 64;

  localparam int GS_BW    = 16;
  localparam int GS_XW    = 32;
  localparam int GS_NBR   = 6;
  localparam int GS_WIN_W = GS_NBR * GS_XW;

  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int GS_IDX_W  = cnt_w(GS_N);
  localparam int GS_ITER_W = cnt_w(GS_ITER);
  // The WAIT counter must be able to hold TIMEOUT itself.
  localparam int GS_TMO_W  = cnt_w(GS_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } gs_state_e;

endpackage

// File: rtl/gs_xbuf.sv
// b/x register file for the solver: one shared index for write and read, plus the
// six-neighbour window around that index with out-of-range slots reading as zero.
module gs_xbuf
  import gs_pkg::*;
#(
  parameter int N     = GS_N,
  parameter int IDX_W = GS_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic                    b_we_i,
  input  logic signed [GS_BW-1:0] b_data_i,
  input  logic                    clear_x_i,
  input  logic                    x_we_i,
  input  logic signed [GS_XW-1:0] x_data_i,
  output logic signed [GS_XW-1:0] b_rd_o,
  output logic signed [GS_XW-1:0] x_rd_o,
  output logic [GS_WIN_W-1:0]     win_o
);

  logic signed [GS_BW-1:0] b_q [N];
  logic signed [GS_XW-1:0] x_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      if (b_we_i) b_q[idx_i] <= b_data_i;
      if (clear_x_i) begin
        for (int i = 0; i < N; i++) x_q[i] <= '0;
      end else if (x_we_i) begin
        x_q[idx_i] <= x_data_i;
      end
    end
  end

  assign b_rd_o = {{(GS_XW-GS_BW){b_q[idx_i][GS_BW-1]}}, b_q[idx_i]};
  assign x_rd_o = x_q[idx_i];

  // Slot s maps to offset -3,-2,-1,+1,+2,+3; slot 0 lands in the top 32 bits.
  always_comb begin
    int off_v;
    int j_v;
    win_o = '0;
    off_v = 0;
    j_v   = 0;
    for (int s = 0; s < GS_NBR; s++) begin
      off_v = (s < 3) ? (s - 3) : (s - 2);
      j_v   = int'(idx_i) + off_v;
      if (j_v >= 0 && j_v < N) begin
        win_o[(GS_NBR-1-s)*GS_XW +: GS_XW] = x_q[j_v[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/gs_controller.sv
// Gauss-Seidel sweep sequencer: loads b, issues one neighbour evaluation at a time to an
// external datapath, writes each result back in place, and streams the solution out.
module gs_controller
  import gs_pkg::*;
#(
  parameter int N       = GS_N,
  parameter int ITER    = GS_ITER,
  parameter int TIMEOUT = GS_TIMEOUT,
  parameter int IDX_W   = GS_IDX_W,
  parameter int ITER_W  = GS_ITER_W,
  parameter int TMO_W   = GS_TMO_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_en,
  input  logic signed [GS_BW-1:0] b_in,
  output logic                    dp_issue_o,
  output logic signed [GS_XW-1:0] dp_b_o,
  output logic [GS_WIN_W-1:0]     dp_x_o,
  input  logic signed [GS_XW-1:0] dp_result_i,
  input  logic                    dp_valid_i,
  output logic                    busy_o,
  output logic                    err_o,
  output logic                    out_valid,
  output logic signed [GS_XW-1:0] x_out,
  output gs_state_e               dbg_state_o
);

  gs_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic                    b_we, clear_x, x_we, dp_active;
  logic signed [GS_XW-1:0] b_rd, x_rd;
  logic [GS_WIN_W-1:0]     win;

  gs_xbuf #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_xbuf (
    .clk       (clk),
    .rst_n     (rst),
    .idx_i     (idx_q),
    .b_we_i    (b_we),
    .b_data_i  (b_in),
    .clear_x_i (clear_x),
    .x_we_i    (x_we),
    .x_data_i  (dp_result_i),
    .b_rd_o    (b_rd),
    .x_rd_o    (x_rd),
    .win_o     (win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      iter_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Datapath handshake: dp_issue_o pulses for one cycle with dp_b_o/dp_x_o valid; those
  // operands hold until the WAIT cycle in which dp_valid_i is seen, which retires the
  // single outstanding evaluation. dp_valid_i in any other state is dropped.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    iter_d     = iter_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    b_we       = 1'b0;
    clear_x    = 1'b0;
    x_we       = 1'b0;
    dp_issue_o = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d  = '0;
        iter_d = '0;
        tmo_d  = '0;
        if (in_en) begin
          b_we    = 1'b1;
          clear_x = 1'b1;
          err_d   = 1'b0;
          idx_d   = IDX_W'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_en) begin
          b_we = 1'b1;
          if (idx_q == IDX_W'(N-1)) begin
            idx_d   = '0;
            iter_d  = '0;
            state_d = S_ISSUE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        dp_issue_o = 1'b1;
        tmo_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the expiry cycle still counts as on time.
        if (dp_valid_i) begin
          x_we  = 1'b1;
          tmo_d = '0;
          if (idx_q != IDX_W'(N-1)) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end else if (iter_q != ITER_W'(ITER-1)) begin
            idx_d   = '0;
            iter_d  = iter_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            idx_d   = '0;
            state_d = S_OUT;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          idx_d   = '0;
          iter_d  = '0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (idx_q == IDX_W'(N-1)) begin
          idx_d   = '0;
          iter_d  = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        iter_d  = '0;
        tmo_d   = '0;
      end
    endcase
  end

  assign dp_active   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign dp_b_o      = dp_active ? b_rd : '0;
  assign dp_x_o      = dp_active ? win : '0;
  assign x_out       = out_valid ? x_rd : '0;
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule
